// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter between the ALU (A) and load unit (B) onto a single register
// file write port, with a pending-write scoreboard set at issue and cleared at writeback.
module rf_wb_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [AW-1:0]    a_rd,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [AW-1:0]    b_rd,
    input  logic [WIDTH-1:0] b_data,
    output logic             rf_we,
    output logic [AW-1:0]    rf_addr,
    output logic [WIDTH-1:0] rf_din,
    output logic [DEPTH-1:0] busy
);

    typedef enum logic {PTR_A, PTR_B} ptr_t;

    ptr_t             ptr;
    logic [DEPTH-1:0] busy_nxt;

    // Grant is decided in the same cycle; the pointer only breaks ties.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (rst) begin
            a_ready = a_valid && (!b_valid || ptr == PTR_A);
            b_ready = b_valid && (!a_valid || ptr == PTR_B);
        end
    end

    // Set is applied after clear so a coincident issue keeps the bit pending.
    always_comb begin
        busy_nxt = busy;
        if (rf_we)
            busy_nxt[rf_addr] = 1'b0;
        if (iss_valid && iss_rd != '0)
            busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr     <= PTR_A;
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_din  <= '0;
            busy    <= '0;
        end else begin
            rf_we <= 1'b0;
            if (a_ready) begin
                rf_we   <= (a_rd != '0);
                rf_addr <= a_rd;
                rf_din  <= a_data;
                ptr     <= PTR_B;
            end else if (b_ready) begin
                rf_we   <= (b_rd != '0);
                rf_addr <= b_rd;
                rf_din  <= b_data;
                ptr     <= PTR_A;
            end
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a reference model predicts readies each
// cycle and queues the expected registered outputs, which are compared after the edge.
module tb_rf_wb_arbiter;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             iss_valid;
    logic [AW-1:0]    iss_rd;
    logic             a_valid, a_ready;
    logic [AW-1:0]    a_rd;
    logic [WIDTH-1:0] a_data;
    logic             b_valid, b_ready;
    logic [AW-1:0]    b_rd;
    logic [WIDTH-1:0] b_data;
    logic             rf_we;
    logic [AW-1:0]    rf_addr;
    logic [WIDTH-1:0] rf_din;
    logic [DEPTH-1:0] busy;

    rf_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_din(rf_din), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             we;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] din;
        logic [DEPTH-1:0] busy;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    logic             m_ptr_b = 1'b0;
    logic             m_we    = 1'b0;
    logic [AW-1:0]    m_addr  = '0;
    logic [WIDTH-1:0] m_din   = '0;
    logic [DEPTH-1:0] m_busy  = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [WIDTH-1:0] ad,
                         input logic bv, input logic [AW-1:0] brd, input logic [WIDTH-1:0] bd,
                         input logic iv, input logic [AW-1:0] ird);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        iss_valid = iv; iss_rd = ird;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    // One clock cycle: check readies before the edge, queue the prediction,
    // then pop and compare the registered outputs just after the edge.
    task automatic step();
        logic ga, gb;
        logic [DEPTH-1:0] nb;
        exp_t e, got;
        #1;
        ga = rst && a_valid && (!b_valid || !m_ptr_b);
        gb = rst && b_valid && (!a_valid ||  m_ptr_b);
        check("a_ready", a_ready, ga);
        check("b_ready", b_ready, gb);
        if (!rst) begin
            e.we = 1'b0; e.addr = '0; e.din = '0; e.busy = '0;
            m_ptr_b = 1'b0;
        end else begin
            e.we = 1'b0; e.addr = m_addr; e.din = m_din;
            if (ga) begin
                e.we = (a_rd != 0); e.addr = a_rd; e.din = a_data; m_ptr_b = 1'b1;
            end else if (gb) begin
                e.we = (b_rd != 0); e.addr = b_rd; e.din = b_data; m_ptr_b = 1'b0;
            end
            nb = m_busy;
            if (m_we) nb[m_addr] = 1'b0;
            if (iss_valid && iss_rd != 0) nb[iss_rd] = 1'b1;
            e.busy = nb;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            got = sb.pop_front();
            check("rf_we", rf_we, got.we);
            check("rf_addr", rf_addr, got.addr);
            check("rf_din", rf_din, got.din);
            check("busy", busy, got.busy);
            check("busy0", busy[0], 1'b0);
            m_we = got.we; m_addr = got.addr; m_din = got.din; m_busy = got.busy;
        end
    endtask

    initial begin
        // Reset with every request asserted
        rst = 1'b0;
        drive(1'b1, 5'd3, 32'h1111, 1'b1, 5'd4, 32'h2222, 1'b1, 5'd3);
        repeat (2) begin
            step();
            check("rst_busy", busy, '0);
            check("rst_we", rf_we, 1'b0);
        end
        rst = 1'b1;
        idle();
        step();

        // Single ALU write
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0);
        #1 check("alu_ready", a_ready, 1'b1);
        step();
        check("alu_we", rf_we, 1'b1);
        check("alu_addr", rf_addr, 5'd5);
        check("alu_din", rf_din, 32'hDEADBEEF);
        idle();
        step();
        check("alu_we_off", rf_we, 1'b0);

        // Contention from reset: A, B, A, B
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd10, 32'hA000 + i, 1'b1, 5'd20, 32'hB000 + i, 1'b0, '0);
            step();
            check("cont_addr", rf_addr, (i % 2 == 0) ? 5'd10 : 5'd20);
        end
        idle();
        step();

        // x0 write from the load unit
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, 1'b0, '0);
        #1 check("x0_ready", b_ready, 1'b1);
        step();
        check("x0_we", rf_we, 1'b0);
        idle();
        step();

        // Scoreboard set, clear, and set-wins coincidence
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        step();
        check("sb_set7", busy[7], 1'b1);
        drive(1'b1, 5'd7, 32'h77, 1'b0, '0, '0, 1'b0, '0);
        step();
        idle();
        step();
        check("sb_clr7", busy[7], 1'b0);
        drive(1'b1, 5'd7, 32'h78, 1'b0, '0, '0, 1'b0, '0);
        step();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        step();
        check("sb_setwins7", busy[7], 1'b1);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd0);
        step();
        check("sb_iss0", busy[0], 1'b0);

        // Mid-operation reset: transfer pending in the output register, then reset
        drive(1'b1, 5'd9, 32'h99, 1'b0, '0, '0, 1'b1, 5'd12);
        step();
        rst = 1'b0;
        idle();
        step();
        check("mid_we", rf_we, 1'b0);
        check("mid_busy", busy, '0);
        // Reset coinciding with a request: no transfer occurs
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd13);
        step();
        rst = 1'b0;
        drive(1'b1, 5'd9, 32'h9A, 1'b1, 5'd8, 32'h8B, 1'b0, '0);
        step();
        check("mid2_we", rf_we, 1'b0);
        rst = 1'b1;
        idle();
        step();
        check("mid2_we_post", rf_we, 1'b0);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            rst = ($urandom_range(0, 39) != 0);
            drive($urandom_range(0, 2) != 0, AW'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 2) != 0, AW'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 1) != 0, AW'($urandom_range(0, 31)));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
